// File: rtl/fc_redundancy_ctrl_pkg.sv
// Shared types and defaults for the temporal-redundancy controller.
// The optional FC_MASK_OUTPUT_EN build macro is handled in the interface and top.
package fc_redundancy_ctrl_pkg;

   localparam int unsigned Y_DEF       = 40;
   localparam int unsigned TAG_W_DEF   = 128;
   localparam int unsigned TIMEOUT_DEF = 4096;
   localparam int unsigned CNT_W_DEF   = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S1   = 3'd1,
      ST_W1   = 3'd2,
      ST_S2   = 3'd3,
      ST_W2   = 3'd4,
      ST_CHK  = 3'd5,
      ST_DONE = 3'd6
   } state_e;

endpackage

// File: rtl/fc_redundancy_ctrl_if.sv
// Request/result and Encryption-core pins of the redundancy controller.
// FC_MASK_OUTPUT_EN adds the random_fault_* output mask inputs.
interface fc_redundancy_ctrl_if
   import fc_redundancy_ctrl_pkg::*;
#(
   parameter int unsigned Y     = Y_DEF,
   parameter int unsigned TAG_W = TAG_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) ();

   logic             req_start;
   logic             busy;
   logic             done;
   logic             core_start;
   logic             core_ready;
   logic [Y-1:0]     core_ct;
   logic [TAG_W-1:0] core_tag;
   logic [Y-1:0]     cipher_text;
   logic [TAG_W-1:0] tag;
   logic             fault;
   logic [CNT_W-1:0] fault_count;
`ifdef FC_MASK_OUTPUT_EN
   logic [TAG_W-1:0] random_fault_1;
   logic [Y-1:0]     random_fault_2;

   modport master (output req_start, core_ready, core_ct, core_tag, random_fault_1, random_fault_2,
                   input  busy, done, core_start, cipher_text, tag, fault, fault_count);
   modport slave  (input  req_start, core_ready, core_ct, core_tag, random_fault_1, random_fault_2,
                   output busy, done, core_start, cipher_text, tag, fault, fault_count);
`else
   modport master (output req_start, core_ready, core_ct, core_tag,
                   input  busy, done, core_start, cipher_text, tag, fault, fault_count);
   modport slave  (input  req_start, core_ready, core_ct, core_tag,
                   output busy, done, core_start, cipher_text, tag, fault, fault_count);
`endif

endinterface

// File: rtl/fc_redundancy_ctrl_watchdog.sv
// Per-run watchdog: counts enabled cycles since the last clear and flags
// the cycle after the count has reached TIMEOUT-1.
module fc_redundancy_ctrl_watchdog
   import fc_redundancy_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam int unsigned CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          expire_q, expire_d;

   always_comb begin
      cnt_d    = cnt_q;
      expire_d = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d    = cnt_q + CW'(1);
         expire_d = (cnt_q == LAST);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         expire_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         expire_q <= expire_d;
      end
   end

   assign expire = expire_q;

endmodule

// File: rtl/fc_redundancy_ctrl.sv
// Runs the Encryption core twice on the same held inputs and releases the result only if both runs agree.
// Build option FC_MASK_OUTPUT_EN: faulty results are replaced by random_fault_* instead of zero.
module fc_redundancy_ctrl
   import fc_redundancy_ctrl_pkg::*;
#(
   parameter int unsigned Y       = Y_DEF,
   parameter int unsigned TAG_W   = TAG_W_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   fc_redundancy_ctrl_if.slave  bus
);

   state_e           state_q, state_d;
   logic             core_ready_q;
   logic [Y-1:0]     run1_ct_q, run1_ct_d;
   logic [TAG_W-1:0] run1_tag_q, run1_tag_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             core_start_q, core_start_d;
   logic [Y-1:0]     ct_q, ct_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             fault_q, fault_d;
   logic [CNT_W-1:0] fault_count_q, fault_count_d;
   logic             wd_clear_q, wd_clear_d;
   logic             wd_en_q, wd_en_d;
   logic             wd_expire;
   logic             fault_now;
   logic [Y-1:0]     mask_ct_c;
   logic [TAG_W-1:0] mask_tag_c;

`ifdef FC_MASK_OUTPUT_EN
   assign mask_ct_c  = bus.random_fault_2;
   assign mask_tag_c = bus.random_fault_1;
`else
   assign mask_ct_c  = '0;
   assign mask_tag_c = '0;
`endif

   // Only a fresh low-to-high edge counts as completion; a level left high by a previous run does not.
   wire ready_rise_c = bus.core_ready & ~core_ready_q;
   wire mismatch_c   = (run1_ct_q != bus.core_ct) | (run1_tag_q != bus.core_tag);
   wire timeout_c    = wd_expire & wd_en_q;

   fc_redundancy_ctrl_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (wd_clear_q),
      .en     (wd_en_q),
      .expire (wd_expire)
   );

   always_comb begin
      state_d       = state_q;
      run1_ct_d     = run1_ct_q;
      run1_tag_d    = run1_tag_q;
      ct_d          = ct_q;
      tag_d         = tag_q;
      fault_d       = fault_q;
      fault_count_d = fault_count_q;
      fault_now     = 1'b0;
      wd_clear_d    = (state_q == ST_S1) | (state_q == ST_S2);
      wd_en_d       = (state_q == ST_W1) | (state_q == ST_W2);

      case (state_q)
         ST_IDLE: if (bus.req_start) begin
            state_d = ST_S1;
            fault_d = 1'b0;
         end
         ST_S1: state_d = ST_W1;
         ST_W1: begin
            if (timeout_c) begin
               state_d   = ST_DONE;
               fault_now = 1'b1;
            end else if (ready_rise_c) begin
               state_d    = ST_S2;
               run1_ct_d  = bus.core_ct;
               run1_tag_d = bus.core_tag;
            end
         end
         ST_S2: state_d = ST_W2;
         ST_W2: begin
            if (timeout_c) begin
               state_d   = ST_DONE;
               fault_now = 1'b1;
            end else if (ready_rise_c) begin
               state_d = ST_CHK;
            end
         end
         ST_CHK: begin
            state_d   = ST_DONE;
            fault_now = mismatch_c;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Results and fault bookkeeping land on the same edge that raises done.
      if (state_d == ST_DONE) begin
         if (fault_now) begin
            fault_d = 1'b1;
            ct_d    = mask_ct_c;
            tag_d   = mask_tag_c;
            if (fault_count_q != {CNT_W{1'b1}}) fault_count_d = fault_count_q + CNT_W'(1);
         end else begin
            ct_d  = run1_ct_q;
            tag_d = run1_tag_q;
         end
      end

      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
      core_start_d = (state_d == ST_S1) | (state_d == ST_S2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         core_ready_q  <= 1'b0;
         run1_ct_q     <= '0;
         run1_tag_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         core_start_q  <= 1'b0;
         ct_q          <= '0;
         tag_q         <= '0;
         fault_q       <= 1'b0;
         fault_count_q <= '0;
         wd_clear_q    <= 1'b0;
         wd_en_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         core_ready_q  <= bus.core_ready;
         run1_ct_q     <= run1_ct_d;
         run1_tag_q    <= run1_tag_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         core_start_q  <= core_start_d;
         ct_q          <= ct_d;
         tag_q         <= tag_d;
         fault_q       <= fault_d;
         fault_count_q <= fault_count_d;
         wd_clear_q    <= wd_clear_d;
         wd_en_q       <= wd_en_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.core_start  = core_start_q;
   assign bus.cipher_text = ct_q;
   assign bus.tag         = tag_q;
   assign bus.fault       = fault_q;
   assign bus.fault_count = fault_count_q;

endmodule
